// File: rtl/fp_scale_pkg.sv
// fp_scale_pkg: shared state encoding, float field constants and field helpers for the pow2 scaler
package fp_scale_pkg;
  localparam int FP_FLOATSIZE = 16;
  localparam int FP_EXPONENTSIZE = 5;
  localparam int SIGNIFICANDSIZE = FP_FLOATSIZE - FP_EXPONENTSIZE - 1;
  localparam int EXP_MAX = (1 << FP_EXPONENTSIZE) - 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic logic fp_sign(input logic [FP_FLOATSIZE-1:0] f);
    return f[FP_FLOATSIZE-1];
  endfunction
  function automatic logic [FP_EXPONENTSIZE-1:0] fp_exp(input logic [FP_FLOATSIZE-1:0] f);
    return f[FP_FLOATSIZE-2 -: FP_EXPONENTSIZE];
  endfunction
  function automatic logic [SIGNIFICANDSIZE-1:0] fp_sig(input logic [FP_FLOATSIZE-1:0] f);
    return f[SIGNIFICANDSIZE-1:0];
  endfunction
endpackage

// File: rtl/fp_pow2_scale_core.sv
// fp_pow2_scale_core: combinational exponent add by a signed runtime power, optional negate, flush to zero
module fp_pow2_scale_core
  import fp_scale_pkg::*;
#(
  parameter int FLOATSIZE = FP_FLOATSIZE,
  parameter int EXPONENTSIZE = FP_EXPONENTSIZE,
  parameter int POWW = 6
) (
  input  logic [FLOATSIZE-1:0] data,
  input  logic [POWW-1:0]      power,
  input  logic                 negate,
  output logic [FLOATSIZE-1:0] result,
  output logic                 flushed
);
  localparam int SW = FLOATSIZE - EXPONENTSIZE - 1;
  localparam int EW = EXPONENTSIZE + 2;
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXPONENTSIZE) - 1);
  logic [EXPONENTSIZE-1:0] exp_in;
  logic signed [EW-1:0] e_new;
  always_comb begin
    exp_in = data[FLOATSIZE-2 -: EXPONENTSIZE];
    e_new = $signed(EW'({1'b0, exp_in})) + EW'($signed(power));
    flushed = exp_in == '0 || e_new[EW-1] || e_new == '0 || e_new > E_MAX;
    result = flushed ? '0 : {data[FLOATSIZE-1] ^ negate, e_new[EXPONENTSIZE-1:0], data[SW-1:0]};
  end
endmodule

// File: rtl/fp_pow2_scale_ctrl.sv
// fp_pow2_scale_ctrl: job sequencer streaming cfg_count floats through a registered pow2 scaling stage
module fp_pow2_scale_ctrl
  import fp_scale_pkg::*;
#(
  parameter int FLOATSIZE = FP_FLOATSIZE,
  parameter int EXPONENTSIZE = FP_EXPONENTSIZE,
  parameter int MAXLEN = 1024,
  parameter int POWW = 6,
  localparam int CNTW = $clog2(MAXLEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [POWW-1:0]      cfg_power,
  input  logic                 cfg_negate,
  input  logic [CNTW-1:0]      cfg_count,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLOATSIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLOATSIZE-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic [CNTW-1:0]      flush_count
);
  state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d, len_q, len_d, flush_q, flush_d;
  logic [POWW-1:0] power_q, power_d;
  logic negate_q, negate_d, out_valid_q, out_valid_d, out_last_q, out_last_d, done_q, done_d;
  logic [FLOATSIZE-1:0] out_data_q, out_data_d, result;
  logic flushed, accept, out_hs;
  fp_pow2_scale_core #(
    .FLOATSIZE(FLOATSIZE),
    .EXPONENTSIZE(EXPONENTSIZE),
    .POWW(POWW)
  ) u_core (
    .data(in_data),
    .power(power_q),
    .negate(negate_q),
    .result(result),
    .flushed(flushed)
  );
  assign cfg_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign in_ready = state_q == RUN && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;
  assign out_hs = out_valid_q && out_ready;
  assign done = done_q || (state_q == DRAIN && out_hs && out_last_q);
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign flush_count = flush_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    flush_d = flush_q;
    power_d = power_q;
    negate_d = negate_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    done_d = 1'b0;
    if (state_q == IDLE && cfg_valid) begin
      power_d = cfg_power;
      negate_d = cfg_negate;
      len_d = cfg_count > CNTW'(MAXLEN) ? CNTW'(MAXLEN) : cfg_count;
      cnt_d = '0;
      flush_d = '0;
      state_d = cfg_count == '0 ? IDLE : RUN;
      done_d = cfg_count == '0;
    end
    if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d = 1'b0;
    end
    // a same-cycle accept overrides the handshake clear so the stage stays full
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d = result;
      out_last_d = cnt_q == len_q - 1'b1;
      cnt_d = cnt_q + 1'b1;
      flush_d = flushed && !(&flush_q) ? flush_q + 1'b1 : flush_q;
      state_d = cnt_q == len_q - 1'b1 ? DRAIN : RUN;
    end
    if (state_q == DRAIN && out_hs && out_last_q) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      len_q <= '0;
      flush_q <= '0;
      power_q <= '0;
      negate_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      flush_q <= flush_d;
      power_q <= power_d;
      negate_q <= negate_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_fp_pow2_scale_ctrl.sv
// tb_fp_pow2_scale_ctrl: directed jobs with hand-computed results, a cycle model of handshakes and backpressure
module tb_fp_pow2_scale_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_negate = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [5:0] cfg_power = '0;
  logic [10:0] cfg_count = '0;
  logic [15:0] in_data = '0;
  logic cfg_ready, in_ready, out_valid, out_last, busy, done;
  logic [15:0] out_data;
  logic [10:0] flush_count;
  logic [15:0] din[1024], dexp[1024];
  int nvec = 0, nerr = 0;
  bit cfg_noise = 1'b0;
  fp_pow2_scale_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_power(cfg_power), .cfg_negate(cfg_negate), .cfg_count(cfg_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cfg(input int p, input logic ng, input int cnt);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_power = 6'(p);
    cfg_negate = ng;
    cfg_count = 11'(cnt);
    #1 chk("cfg_ready", cfg_ready, 1);
  endtask
  task automatic run_job(input int n, input logic [15:0] stall, input int exp_flush);
    bit ov = 1'b0;
    int acc = 0, got = 0, cyc = 0;
    logic er, hs, ac;
    while (got < n && cyc < n * 4 + 40) begin
      @(negedge clk);
      cfg_valid = cfg_noise;
      if (cfg_noise) begin
        cfg_power = 6'd5;
        cfg_count = '0;
      end
      out_ready = !(cyc < 16 && stall[cyc % 16]);
      in_valid = acc < n;
      in_data = din[acc < n ? acc : n - 1];
      #1;
      er = acc < n && (!ov || out_ready);
      chk("in_ready", in_ready, er);
      chk("out_valid", out_valid, ov);
      chk("busy", busy, 1);
      if (cfg_noise) chk("cfg_ready_run", cfg_ready, 0);
      if (ov) begin
        chk("out_data", out_data, dexp[got]);
        chk("out_last", out_last, got == n - 1);
      end
      hs = ov && out_ready;
      chk("done", done, hs && got == n - 1);
      ac = in_valid && er;
      if (hs) got++;
      ov = ac ? 1'b1 : (hs ? 1'b0 : ov);
      if (ac) acc++;
      cyc++;
    end
    chk("job_complete", got, n);
    @(negedge clk);
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_done", done, 0);
    chk("flush_count", flush_count, exp_flush);
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_flush", flush_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    din[0] = 16'h3C00; dexp[0] = 16'h4400;
    cfg(2, 0, 1); run_job(1, 16'h0, 0);
    din[0] = 16'h3C00; dexp[0] = 16'hB000;
    din[1] = 16'h4000; dexp[1] = 16'hB400;
    cfg(-3, 1, 2); run_job(2, 16'h0, 0);
    din[0] = 16'h7800; dexp[0] = 16'h0000;
    din[1] = 16'h0001; dexp[1] = 16'h0000;
    din[2] = 16'h3C00; dexp[2] = 16'h4400;
    cfg(2, 0, 3); run_job(3, 16'h0, 2);
    din[0] = 16'h3C00; dexp[0] = 16'h0400;
    din[1] = 16'hBC01; dexp[1] = 16'h8401;
    cfg(-14, 0, 2); run_job(2, 16'h0, 0);
    din[0] = 16'h3C00; dexp[0] = 16'h7C00;
    din[1] = 16'h4000; dexp[1] = 16'h0000;
    cfg(16, 0, 2); run_job(2, 16'h0, 1);
    din[0] = 16'h3C00; dexp[0] = 16'h0000;
    din[1] = 16'h4000; dexp[1] = 16'h8400;
    cfg(-15, 1, 2); run_job(2, 16'h0, 1);
    din[0] = 16'h3C00; dexp[0] = 16'h4000;
    din[1] = 16'h4000; dexp[1] = 16'h4400;
    din[2] = 16'h4200; dexp[2] = 16'h4600;
    din[3] = 16'h4400; dexp[3] = 16'h4800;
    cfg(1, 0, 4); run_job(4, 16'h000E, 0);
    cfg(5, 0, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("zero_done_pulse", done, 0);
    chk("zero_busy_after", busy, 0);
    din[0] = 16'h3C00; dexp[0] = 16'h3C00;
    din[1] = 16'hC000; dexp[1] = 16'hC000;
    cfg_noise = 1'b1;
    cfg(0, 0, 2); run_job(2, 16'h0, 0);
    cfg_noise = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      din[i] = 16'h3C00;
      dexp[i] = 16'h3C00;
    end
    cfg(0, 0, 1100); run_job(1024, 16'h0, 0);
    cfg(0, 0, 5);
    @(negedge clk);
    cfg_valid = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h0001;
    @(negedge clk);
    in_data = 16'h3C00;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_flush", flush_count, 1);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_flush", flush_count, 0);
    chk("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    din[0] = 16'h3C00; dexp[0] = 16'h4400;
    cfg(2, 0, 1); run_job(1, 16'h0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fp_pow2_scale_ctrl.md
Name: fp_pow2_scale_ctrl

Overview:
Job-based streaming controller that applies a runtime power-of-two scale (exponent add), with optional negation, to a burst of packed floats.
- Sits between an activation buffer and the next layer's input FIFO in the inference datapath. Used for layer requantisation and sign flips.
- Accepts one configuration per job, sequences exactly cfg_count elements through a registered scaling stage with valid/ready backpressure, and reports flushed elements.

Parameters:
FLOATSIZE, 16, total float width
EXPONENTSIZE, 5, exponent field width; significand = FLOATSIZE-EXPONENTSIZE-1
MAXLEN, 1024, maximum elements per job
POWW, 6, width of signed runtime power
CNTW, $clog2(MAXLEN+1), width of element/flush counters (localparam)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
cfg_valid  in  1  job configuration offered
cfg_ready  out  1  high only in IDLE
cfg_power  in  POWW  signed exponent delta
cfg_negate  in  1  invert sign of every non-flushed result
cfg_count  in  CNTW  elements in job (0..MAXLEN)
in_valid  in  1  input element valid
in_ready  out  1  controller accepts element
in_data  in  FLOATSIZE  input float
out_valid  out  1  output register holds a result
out_ready  in  1  downstream accepts
out_data  out  FLOATSIZE  scaled float
out_last  out  1  out_data is final element of job
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion
flush_count  out  CNTW  elements flushed to zero in current/last job

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, out_data=0, out_last=0, done=0, flush_count=0, element counter=0. Applies mid-job; the partial job is discarded.
- States: IDLE, RUN, DRAIN.
- IDLE: cfg_ready=1. On cfg_valid, latch power/negate/count and clear flush_count and the element counter.
  - count>0: go to RUN.
  - count==0: stay IDLE and pulse done next cycle.
- RUN: in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready. out_data/out_valid update on the next edge, so latency is 1 cycle.
  - Counter increments per accept. The accept of element count-1 sets out_last and moves to DRAIN.
- DRAIN: in_ready=0. When out_valid && out_ready && out_last, go to IDLE, pulse done in the same cycle as that handshake, and clear out_valid.
- Output register: holds value while out_valid && !out_ready. Clears out_valid on handshake with no new accept. Simultaneous handshake and accept loads the new value with out_valid staying 1.
- Arithmetic: e_new = signed {0,exp} + sign-extended power, evaluated at EXPONENTSIZE+2 bits.
  - Result field: {sign ^ negate, e_new[EXPONENTSIZE-1:0], significand}.
  - Flush to all-zero word (sign included) if input exp==0, e_new<1, or e_new>2^EXPONENTSIZE-1. Flushing increments flush_count, saturating at all-ones.
  - Exponent all-ones inputs are not special-cased.
- cfg_valid outside IDLE is ignored.
- cfg_count>MAXLEN is clamped to MAXLEN.

Decomposition:
- Package fp_scale_pkg: state enum (IDLE/RUN/DRAIN), localparams for SIGNIFICANDSIZE, EXP_MAX, and the field-extraction helper functions.
- One combinational sub-module, fp_pow2_scale_core: inputs data, power, negate; outputs result and flushed flag. This is the runtime-power counterpart of the fixed-power scaler.
- The controller owns the FSM, counters and output register.

Test Plan:
- Scale up: cfg_power=+2, count=1, in 0x3C00 (1.0) -> out 0x4400 one cycle after accept, out_last=1, done pulse, flush_count=0.
- Scale down with negate: cfg_power=-3, negate=1, in 0x3C00 -> 0xB000; in 0x4000 (2.0) -> 0xB400.
- Flush: power=+2, count=3, in 0x7800, 0x0001, 0x3C00 -> 0x0000, 0x0000, 0x4400; flush_count=2.
- Backpressure: count=4, in_valid held high, out_ready low cycles 2-4 -> out_data stable while stalled, in_ready low, all 4 elements in order, done only after 4th handshake.
- Zero-length and config gating: count=0 -> done next cycle, busy stays 0; cfg_valid during RUN -> ignored.
- Reset mid-job: rst_n low after 2 of 5 elements -> out_valid=0, busy=0, flush_count=0 immediately. A new job then runs cleanly.
